dram_mp: RTL and testbench
==========================

// Module: dram_mp
// PURPOSE
//  Parametrised multi-read-port distributed RAM, successor to the 2-port dram.
//  One write port with byte enables, RDPORTS read ports, optional registered reads with
//  write-first bypass, and a sequential clear engine that fills the array with INITVAL.
//  Used for register files, tag arrays and small tables that must start in a known state.
// PARAMETERS
//  SZ       2    entries; AW = clog2(SZ)
//  DW       32   data width; DW%8==0; SW = DW/8 byte selects
//  RDPORTS  2    number of read ports, >=1
//  RDREG    0    0: combinational read; 1: read data registered, latency 1
//  BYPASS   1    RDREG=1 only: same-cycle write to a read address forwards new bytes
//  CLRONRST 1    1: clear engine runs automatically after reset release
//  INITVAL  0    DW-bit value written by clear engine
//  SRCFILE  ""   $readmemh preload; the preload is lost if a clear runs
// PORTS
//  clk_i    in   1           clock, all state on posedge
//  rst_ni   in   1           asynchronous active-low reset
//  clr_i    in   1           request clear of whole array (sampled when rdy_o=1)
//  rdy_o    out  1           1: not clearing; writes accepted
//  we_i     in   1           write enable
//  sel_i    in   SW          byte enables; bit b covers wdata_i[8b+7:8b]
//  waddr_i  in   AW          write address
//  wdata_i  in   DW          write data
//  raddr_i  in   RDPORTS*AW  read addresses, port p at [p*AW +: AW]
//  rdata_o  out  RDPORTS*DW  read data, port p at [p*DW +: DW]
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=CLEAR with cnt=0 if CLRONRST=1, else READY;
//   rdy_o=!CLRONRST; rdata_o registers (RDREG=1) =0. Array contents not touched by reset.
//  FSM READY: rdy_o=1. we_i=1 -> u[waddr_i] bytes with sel_i=1 take wdata_i at posedge;
//   sel_i=0 bytes keep old value; we_i=1 with sel_i=0 is a no-op.
//   clr_i=1 -> CLEAR, cnt=0; a write in the same cycle is still performed
//   (the clear then overwrites it).
//  FSM CLEAR: rdy_o=0; each cycle u[cnt]<=INITVAL, cnt<=cnt+1; at cnt==SZ-1 write last
//   entry and go READY next edge. Exactly SZ cycles with rdy_o=0. we_i and clr_i ignored.
//   cnt is AW bits; SZ not a power of 2 terminates on cnt==SZ-1, no wrap into
//   unused addresses.
//  Reset mid-clear: restart from cnt=0 (CLRONRST=1) or abort to READY (CLRONRST=0,
//   array left partially cleared).
//  Read, RDREG=0: rdata_o[p] = u[raddr_i[p]] combinationally; a write shows up after the
//   edge that performs it (old data during the write cycle).
//  Read, RDREG=1: rdata_o[p] <= u[raddr_i[p]] each posedge, latency 1, in every state.
//   BYPASS=1: if an accepted write has waddr_i==raddr_i[p] in the same cycle, the
//   registered value = new bytes where sel_i=1, old bytes elsewhere (write-first).
//   During CLEAR, reads of u[cnt] with BYPASS=1 return INITVAL.
//   BYPASS=0: read-first, old word.
//  Out-of-range addresses (>=SZ): write ignored, read data undefined.
//  All read ports independent; any ports may share an address.
// TESTING
//  1 SZ=8,CLRONRST=1,INITVAL=32'hA5A5A5A5: release reset -> rdy_o=0 for 8 cycles, then 1;
//    all 8 entries read A5A5A5A5.
//  2 Write 0x11223344 @3 sel=4'hF, then 0xAABBCCDD @3 sel=4'b0101 -> port0 @3 reads 0x11BB33DD.
//  3 RDREG=1,BYPASS=1: write 0xDEADBEEF @5 while raddr port1=5 -> next cycle rdata1=0xDEADBEEF;
//    BYPASS=0 -> old value, new one cycle later.
//  4 clr_i pulse in READY with we_i=1 @2 data 7 -> rdy_o low SZ cycles; @2 ends as INITVAL.
//  5 rst_ni low at cnt=4 of clear -> restart; rdy_o low full SZ cycles after release.
//  6 RDPORTS=4, all ports same/different addresses over random writes -> matches scoreboard.

Source files
------------

// File: rtl/dram_mp_if.sv
// Bus bundle for dram_mp: one byte-enabled write port, a clear request and
// RDPORTS flat read ports.
interface dram_mp_if #(
    parameter int SZ      = 2,
    parameter int DW      = 32,
    parameter int RDPORTS = 2
);
    localparam int AW = (SZ > 1) ? $clog2(SZ) : 1;
    localparam int SW = DW / 8;

    // Handshake: rdy_o is the ready side. we_i and clr_i are one-cycle requests
    // that take effect only on a posedge where rdy_o=1; while rdy_o=0 they are
    // dropped, not held. Reads have no handshake and are valid in every state.
    logic                  clr_i;
    logic                  rdy_o;
    logic                  we_i;
    logic [SW-1:0]         sel_i;
    logic [AW-1:0]         waddr_i;
    logic [DW-1:0]         wdata_i;
    logic [RDPORTS*AW-1:0] raddr_i;
    logic [RDPORTS*DW-1:0] rdata_o;

    modport master (
        output clr_i, we_i, sel_i, waddr_i, wdata_i, raddr_i,
        input  rdy_o, rdata_o
    );

    modport slave (
        input  clr_i, we_i, sel_i, waddr_i, wdata_i, raddr_i,
        output rdy_o, rdata_o
    );
endinterface

// File: rtl/dram_mp.sv
// Multi-read-port distributed RAM with byte-enable writes, optional registered
// reads with write-first bypass, and a sequential clear engine filling INITVAL.
module dram_mp #(
    parameter int             SZ       = 2,
    parameter int             DW       = 32,
    parameter int             RDPORTS  = 2,
    parameter int             RDREG    = 0,
    parameter int             BYPASS   = 1,
    parameter int             CLRONRST = 1,
    parameter logic [DW-1:0]  INITVAL  = '0,
    parameter                 SRCFILE  = "",
    localparam int            AW       = (SZ > 1) ? $clog2(SZ) : 1,
    localparam int            SW       = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    dram_mp_if.slave      bus,
    output logic          dbg_clear_o,
    output logic [AW-1:0] dbg_cnt_o
);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(SZ - 1);

    state_e                state;
    logic [AW-1:0]         cnt;
    logic                  rdy_q;
    logic [DW-1:0]         mem [SZ];
    logic                  clearing;
    logic                  wr_acc;
    logic [RDPORTS*DW-1:0] rd_comb;
    logic [RDPORTS*DW-1:0] rd_next;
    logic [RDPORTS*DW-1:0] rd_q;

    assign clearing = (state == ST_CLEAR);
    // Out-of-range write addresses are dropped rather than aliased.
    assign wr_acc   = !clearing && bus.we_i && (int'(bus.waddr_i) < SZ);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= (CLRONRST != 0) ? ST_CLEAR : ST_READY;
            cnt   <= '0;
            rdy_q <= (CLRONRST == 0);
        end else begin
            case (state)
                ST_READY: begin
                    if (bus.clr_i) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        rdy_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // Terminate on the last real entry so non-power-of-2 sizes never wrap.
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        cnt   <= '0;
                        rdy_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_READY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (clearing) begin
                mem[cnt] <= INITVAL;
            end else if (wr_acc) begin
                for (int b = 0; b < SW; b++) begin
                    if (bus.sel_i[b]) mem[bus.waddr_i][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_comb = '0;
        rd_next = '0;
        for (int p = 0; p < RDPORTS; p++) begin
            logic [AW-1:0] ra;
            logic [DW-1:0] word;
            ra   = bus.raddr_i[p*AW +: AW];
            word = mem[ra];
            rd_comb[p*DW +: DW] = word;
            if (BYPASS != 0) begin
                if (wr_acc && (bus.waddr_i == ra)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (bus.sel_i[b]) word[8*b +: 8] = bus.wdata_i[8*b +: 8];
                    end
                end
                if (clearing && (cnt == ra)) word = INITVAL;
            end
            rd_next[p*DW +: DW] = word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_q <= '0;
        else         rd_q <= rd_next;
    end

    assign bus.rdata_o = (RDREG != 0) ? rd_q : rd_comb;
    assign bus.rdy_o   = rdy_q;
    assign dbg_clear_o = clearing;
    assign dbg_cnt_o   = cnt;

endmodule

// File: tb/tb_dram_mp.sv
// Bench for dram_mp: a combinational 4-port instance plus registered 2-port
// instances with and without bypass, all fed the same write/clear stream.
module tb_dram_mp;
    localparam int          SZ   = 8;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [2:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  ra [4];

    logic        dc_c, dc_b, dc_n;
    logic [2:0]  dn_c, dn_b, dn_n;

    logic [31:0] mdl [SZ];
    int          clr_left = 0;
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    dram_mp_if #(.SZ(SZ), .DW(32), .RDPORTS(4)) if_c ();
    dram_mp_if #(.SZ(SZ), .DW(32), .RDPORTS(2)) if_b ();
    dram_mp_if #(.SZ(SZ), .DW(32), .RDPORTS(2)) if_n ();

    assign if_c.clr_i = clr;   assign if_b.clr_i = clr;   assign if_n.clr_i = clr;
    assign if_c.we_i = we;     assign if_b.we_i = we;     assign if_n.we_i = we;
    assign if_c.sel_i = sel;   assign if_b.sel_i = sel;   assign if_n.sel_i = sel;
    assign if_c.waddr_i = waddr; assign if_b.waddr_i = waddr; assign if_n.waddr_i = waddr;
    assign if_c.wdata_i = wdata; assign if_b.wdata_i = wdata; assign if_n.wdata_i = wdata;
    assign if_c.raddr_i = {ra[3], ra[2], ra[1], ra[0]};
    assign if_b.raddr_i = {ra[1], ra[0]};
    assign if_n.raddr_i = {ra[1], ra[0]};

    dram_mp #(.SZ(SZ), .DW(32), .RDPORTS(4), .RDREG(0), .BYPASS(1), .CLRONRST(1), .INITVAL(INIT))
        u_c (.clk_i(clk), .rst_ni(rst_n), .bus(if_c), .dbg_clear_o(dc_c), .dbg_cnt_o(dn_c));
    dram_mp #(.SZ(SZ), .DW(32), .RDPORTS(2), .RDREG(1), .BYPASS(1), .CLRONRST(1), .INITVAL(INIT))
        u_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b), .dbg_clear_o(dc_b), .dbg_cnt_o(dn_b));
    dram_mp #(.SZ(SZ), .DW(32), .RDPORTS(2), .RDREG(1), .BYPASS(0), .CLRONRST(1), .INITVAL(INIT))
        u_n (.clk_i(clk), .rst_ni(rst_n), .bus(if_n), .dbg_clear_o(dc_n), .dbg_cnt_o(dn_n));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Advance one clock; queue expected registered reads (bypass, read-first)
    // for ports 0/1 when the array model is valid, then update the model.
    task automatic tick();
        logic [31:0] old;
        exp_q.delete();
        if (clr_left == 0) begin
            for (int p = 0; p < 2; p++) begin
                old = mdl[ra[p]];
                exp_q.push_back((we && waddr == ra[p]) ? merge(old, wdata, sel) : old);
                exp_q.push_back(old);
            end
            if (we) mdl[waddr] = merge(mdl[waddr], wdata, sel);
            if (clr) clr_left = SZ;
        end else begin
            clr_left--;
            if (clr_left == 0) for (int a = 0; a < SZ; a++) mdl[a] = INIT;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int p = 0; p < 4; p++) ra[p] = 3'(p);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({if_c.rdy_o, if_b.rdy_o, if_n.rdy_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_rdy: got %b expected 000", {if_c.rdy_o, if_b.rdy_o, if_n.rdy_o});
        end
        n_checks++;
        if ({if_b.rdata_o, if_n.rdata_o} !== 128'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", if_b.rdata_o, if_n.rdata_o);
        end
        n_checks++;
        if ({dc_c, dn_c} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_state: got clear=%b cnt=%0d expected clear=1 cnt=0", dc_c, dn_c);
        end
        rst_n = 1'b1;
        clr_left = SZ;
    endtask

    task automatic check_clear_window(input string name);
        for (int i = 0; i < SZ; i++) begin
            n_checks++;
            if ({if_c.rdy_o, if_b.rdy_o, if_n.rdy_o} !== 3'b000) begin
                n_fail++; $display("FAIL %s_busy cycle %0d: rdy got %b expected 000", name, i,
                                   {if_c.rdy_o, if_b.rdy_o, if_n.rdy_o});
            end
            tick();
        end
        n_checks++;
        if ({if_c.rdy_o, if_b.rdy_o, if_n.rdy_o} !== 3'b111) begin
            n_fail++; $display("FAIL %s_done: rdy got %b expected 111", name, {if_c.rdy_o, if_b.rdy_o, if_n.rdy_o});
        end
    endtask

    task automatic test_clear_after_reset();
        check_clear_window("rst_clear");
        for (int a = 0; a < SZ; a++) begin
            ra[0] = 3'(a); ra[1] = 3'(SZ - 1 - a); ra[2] = 3'(SZ - 1 - a); ra[3] = 3'(a);
            #1;
            n_checks++;
            if (if_c.rdata_o[31:0] !== INIT || if_c.rdata_o[95:64] !== INIT) begin
                n_fail++; $display("FAIL init_comb @%0d: got %h/%h expected %h", a,
                                   if_c.rdata_o[31:0], if_c.rdata_o[95:64], INIT);
            end
            tick();
            n_checks++;
            if (if_b.rdata_o[31:0] !== INIT || if_n.rdata_o[63:32] !== INIT) begin
                n_fail++; $display("FAIL init_reg @%0d: got %h/%h expected %h", a,
                                   if_b.rdata_o[31:0], if_n.rdata_o[63:32], INIT);
            end
        end
    endtask

    task automatic test_byte_enable();
        we = 1'b1; waddr = 3'd3; wdata = 32'h11223344; sel = 4'hF;
        tick();
        wdata = 32'hAABBCCDD; sel = 4'b0101;
        tick();
        wdata = 32'hFFFFFFFF; sel = 4'h0;
        tick();
        we = 1'b0; ra[0] = 3'd3;
        #1;
        n_checks++;
        if (if_c.rdata_o[31:0] !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL byte_enable: got %h expected 11bb33dd", if_c.rdata_o[31:0]);
        end
        tick();
        n_checks++;
        if (if_b.rdata_o[31:0] !== 32'h11BB33DD || if_n.rdata_o[31:0] !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL byte_enable_reg: got %h/%h expected 11bb33dd",
                               if_b.rdata_o[31:0], if_n.rdata_o[31:0]);
        end
    endtask

    task automatic test_bypass();
        ra[0] = 3'd1; ra[1] = 3'd5;
        we = 1'b1; waddr = 3'd5; wdata = 32'hDEADBEEF; sel = 4'hF;
        #1;
        n_checks++;
        if (if_c.rdata_o[63:32] !== INIT) begin
            n_fail++; $display("FAIL comb_old_during_write: got %h expected %h", if_c.rdata_o[63:32], INIT);
        end
        tick();
        we = 1'b0;
        n_checks++;
        if (if_b.rdata_o[63:32] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bypass_new: got %h expected deadbeef", if_b.rdata_o[63:32]);
        end
        n_checks++;
        if (if_n.rdata_o[63:32] !== INIT) begin
            n_fail++; $display("FAIL readfirst_old: got %h expected %h", if_n.rdata_o[63:32], INIT);
        end
        tick();
        n_checks++;
        if (if_n.rdata_o[63:32] !== 32'hDEADBEEF || if_c.rdata_o[63:32] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL readfirst_late: got %h/%h expected deadbeef",
                               if_n.rdata_o[63:32], if_c.rdata_o[63:32]);
        end
    endtask

    task automatic test_clr_with_write();
        clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 32'h7; sel = 4'hF;
        tick();
        clr = 1'b0; waddr = 3'd4; wdata = 32'h12345678;
        for (int i = 0; i < SZ; i++) begin
            n_checks++;
            if ({if_c.rdy_o, if_b.rdy_o, if_n.rdy_o} !== 3'b000) begin
                n_fail++; $display("FAIL clr_busy cycle %0d: rdy got %b expected 000", i,
                                   {if_c.rdy_o, if_b.rdy_o, if_n.rdy_o});
            end
            clr = (i == 3);
            tick();
        end
        clr = 1'b0; we = 1'b0;
        n_checks++;
        if ({if_c.rdy_o, if_b.rdy_o, if_n.rdy_o} !== 3'b111) begin
            n_fail++; $display("FAIL clr_done: rdy got %b expected 111", {if_c.rdy_o, if_b.rdy_o, if_n.rdy_o});
        end
        ra[0] = 3'd2; ra[1] = 3'd4; ra[2] = 3'd5; ra[3] = 3'd3;
        #1;
        n_checks++;
        if (if_c.rdata_o !== {INIT, INIT, INIT, INIT}) begin
            n_fail++; $display("FAIL clr_contents: got %h expected all %h", if_c.rdata_o, INIT);
        end
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; waddr = 3'd6; wdata = 32'h0BADF00D; sel = 4'hF;
        tick();
        we = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (dn_c !== 3'd4 || dc_c !== 1'b1) begin
            n_fail++; $display("FAIL mid_clear_cnt: got clear=%b cnt=%0d expected clear=1 cnt=4", dc_c, dn_c);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dn_c !== 3'd0 || if_b.rdata_o !== 64'd0 || if_c.rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got cnt=%0d rdata=%h rdy=%b expected 0/0/0",
                               dn_c, if_b.rdata_o, if_c.rdy_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_left = SZ;
        check_clear_window("restart");
        ra[0] = 3'd6; ra[1] = 3'd7; ra[2] = 3'd0; ra[3] = 3'd4;
        #1;
        n_checks++;
        if (if_c.rdata_o !== {INIT, INIT, INIT, INIT}) begin
            n_fail++; $display("FAIL restart_contents: got %h expected all %h", if_c.rdata_o, INIT);
        end
    endtask

    task automatic test_random();
        logic [31:0] eb, en;
        for (int it = 0; it < 400; it++) begin
            we    = ($urandom_range(0, 3) != 0);
            sel   = 4'($urandom_range(0, 15));
            waddr = 3'($urandom_range(0, SZ - 1));
            wdata = $urandom;
            clr   = (clr_left == 0) && ($urandom_range(0, 59) == 0);
            ra[0] = 3'($urandom_range(0, SZ - 1));
            for (int p = 1; p < 4; p++)
                ra[p] = ($urandom_range(0, 2) == 0) ? ra[0] : 3'($urandom_range(0, SZ - 1));
            if ($urandom_range(0, 3) == 0) ra[1] = waddr;
            #1;
            if (clr_left == 0) begin
                for (int p = 0; p < 4; p++) begin
                    n_checks++;
                    if (if_c.rdata_o[p*32 +: 32] !== mdl[ra[p]]) begin
                        n_fail++; $display("FAIL rand_comb it %0d port %0d @%0d: got %h expected %h",
                                           it, p, ra[p], if_c.rdata_o[p*32 +: 32], mdl[ra[p]]);
                    end
                end
            end
            tick();
            if (exp_q.size() == 4) begin
                for (int p = 0; p < 2; p++) begin
                    eb = exp_q.pop_front();
                    en = exp_q.pop_front();
                    n_checks++;
                    if (if_b.rdata_o[p*32 +: 32] !== eb || if_n.rdata_o[p*32 +: 32] !== en) begin
                        n_fail++; $display("FAIL rand_reg it %0d port %0d: got byp=%h rf=%h expected %h/%h",
                                           it, p, if_b.rdata_o[p*32 +: 32], if_n.rdata_o[p*32 +: 32], eb, en);
                    end
                end
            end
            n_checks++;
            if (if_c.rdy_o !== (clr_left == 0) || if_b.rdy_o !== (clr_left == 0)) begin
                n_fail++; $display("FAIL rand_rdy it %0d: got %b/%b expected %b", it,
                                   if_c.rdy_o, if_b.rdy_o, (clr_left == 0));
            end
        end
        we = 1'b0; clr = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clear_after_reset();
        test_byte_enable();
        test_bypass();
        test_clr_with_write();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
